// File: rtl/id_stage.sv
// id_stage: registered instruction-decode stage with valid/ready handshake.
// Optional register scoreboard (RAW/WAW stall) enabled by defining ID_SCOREBOARD_EN.
// Instruction layout: rs1=[IW-1 -: RFW], rd=[IW-1-RFW -: RFW], rs2=[IW-1-2*RFW -: RFW], op=[0].

`ifndef OP_R
`define OP_R 1'b1
`endif
`ifndef REG0
`define REG0 0
`endif

module id_stage #(
  parameter int unsigned IW  = 8,
  parameter int unsigned RFW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  instruction,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_rf_we,
  output logic [RFW-1:0] out_rs1_address,
  output logic [RFW-1:0] out_rs2_address,
  output logic [RFW-1:0] out_rd_address,
  input  logic           wb_valid,
  input  logic [RFW-1:0] wb_rd_address,
  input  logic           flush
);

  logic           op;
  logic [RFW-1:0] rs1;
  logic [RFW-1:0] rs2;
  logic [RFW-1:0] rd;
  logic           rf_we;
  logic           hazard;
  logic           accept;

  // Field extraction and write-enable decode
  always_comb begin
    op    = instruction[0];
    rs1   = instruction[IW-1 -: RFW];
    rd    = instruction[IW-1-RFW -: RFW];
    rs2   = instruction[IW-1-2*RFW -: RFW];
    rf_we = (op == `OP_R) && (rd != RFW'(`REG0));
  end

  // Bits between rs2 and op carry no meaning for this stage
  if (IW > 3*RFW + 1) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^instruction[IW-3*RFW-1:1];
  end

`ifdef ID_SCOREBOARD_EN
  localparam int unsigned NREG = 2**RFW;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] live;
  logic [NREG-1:0] set_mask;

  // Writeback clears its register in the same cycle it completes
  always_comb begin
    clr_mask = '0;
    if (wb_valid) clr_mask = NREG'(1) << wb_rd_address;
    live   = pending & ~clr_mask;
    hazard = live[rs1] | live[rs2] | (rf_we & live[rd]);
  end

  // Accepted writer marks its destination in flight (rd never REG0 here)
  always_comb begin
    set_mask = '0;
    if (accept && rf_we) set_mask = NREG'(1) << rd;
  end

  // Scoreboard register: set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst || flush) pending <= '0;
    else              pending <= live | set_mask;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd_address};
  assign hazard    = 1'b0;
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, drop valid on consume or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_rf_we       <= 1'b0;
      out_rs1_address <= '0;
      out_rs2_address <= '0;
      out_rd_address  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_rf_we <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_rf_we       <= rf_we;
      out_rs1_address <= rs1;
      out_rs2_address <= rs2;
      out_rd_address  <= rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage (IW=8, RFW=2), scenario tasks plus randomized run
// against a behavioural model; honours ID_SCOREBOARD_EN like the design.

module tb_id_stage;

`ifdef ID_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] instruction = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_rf_we;
  logic [1:0] out_rs1_address;
  logic [1:0] out_rs2_address;
  logic [1:0] out_rd_address;
  logic       wb_valid = 1'b0;
  logic [1:0] wb_rd_address = '0;
  logic       flush = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit       m_valid, m_we;
  bit [1:0] m_rs1, m_rs2, m_rd;
  bit       pend [4];

  id_stage #(.IW(8), .RFW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .out_rf_we(out_rf_we), .out_rs1_address(out_rs1_address),
    .out_rs2_address(out_rs2_address), .out_rd_address(out_rd_address),
    .wb_valid(wb_valid), .wb_rd_address(wb_rd_address), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input int rs1, input int rd, input int rs2, input int op);
    logic [1:0] a, b, c;
    a = 2'(rs1); b = 2'(rd); c = 2'(rs2);
    return {a, b, c, 1'b0, 1'(op)};
  endfunction

  // Register r still has a write in flight after this cycle's writeback
  function automatic bit busy(input int r);
    return SB && pend[r] && !(wb_valid && int'(wb_rd_address) == r);
  endfunction

  function automatic bit m_writes();
    return instruction[0] && (instruction[5:4] != 2'd0);
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = busy(int'(instruction[7:6])) || busy(int'(instruction[3:2])) ||
         (m_writes() && busy(int'(instruction[5:4])));
    return (!m_valid || out_ready) && !hz && !flush;
  endfunction

  function automatic logic [8:0] m_out();
    return {m_valid, m_we, m_rs1, m_rd, m_rs2};
  endfunction

  function automatic logic [8:0] d_out();
    return {out_valid, out_rf_we, out_rs1_address, out_rd_address, out_rs2_address};
  endfunction

  // Advance one clock; model consumes the inputs present at the edge
  task automatic tick();
    bit acc, nxt [4];
    acc = in_valid && m_ready();
    for (int r = 0; r < 4; r++)
      nxt[r] = busy(r) || (acc && m_writes() && int'(instruction[5:4]) == r);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_we = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      for (int r = 0; r < 4; r++) pend[r] = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0;
      for (int r = 0; r < 4; r++) pend[r] = 0;
    end else begin
      for (int r = 0; r < 4; r++) pend[r] = nxt[r];
      if (acc) begin
        m_valid = 1; m_we = m_writes();
        m_rs1 = instruction[7:6]; m_rd = instruction[5:4]; m_rs2 = instruction[3:2];
      end else if (out_ready) begin
        m_valid = 0; m_we = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] ins, input bit ordy,
                       input bit wbv, input int wba, input bit fl);
    @(negedge clk);
    in_valid = v; instruction = ins; out_ready = ordy;
    wb_valid = wbv; wb_rd_address = 2'(wba); flush = fl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    tick(); tick();
    n_checks++;
    if (d_out() !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want %h", d_out(), 9'd0);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    drive(1'b1, mk(1, 2, 3, 1), 1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL decode_ready got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (d_out() !== {1'b1, 1'b1, 2'd1, 2'd2, 2'd3}) begin
      n_fail++; $display("FAIL decode_writer got %h want %h", d_out(), {1'b1, 1'b1, 2'd1, 2'd2, 2'd3});
    end
    drive(1'b1, mk(1, 0, 3, 1), 1'b1, 1'b0, 0, 1'b0);
    tick();
    n_checks++;
    if (d_out() !== {1'b1, 1'b0, 2'd1, 2'd0, 2'd3}) begin
      n_fail++; $display("FAIL decode_rd0 got %h want %h", d_out(), {1'b1, 1'b0, 2'd1, 2'd0, 2'd3});
    end
  endtask

  task automatic test_raw_stall();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, mk(2, 1, 0, 0), 1'b1, 1'b0, 0, 1'b0);
      n_checks++;
      if (in_ready !== m_ready()) begin
        n_fail++; $display("FAIL raw_stall_ready cyc %0d got %b want %b", c, in_ready, m_ready());
      end
      tick();
    end
    drive(1'b1, mk(2, 1, 0, 0), 1'b1, 1'b1, 2, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_bypass_ready got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (d_out() !== {1'b1, 1'b0, 2'd2, 2'd1, 2'd0}) begin
      n_fail++; $display("FAIL raw_accept got %h want %h", d_out(), {1'b1, 1'b0, 2'd2, 2'd1, 2'd0});
    end
    drive(1'b1, mk(2, 2, 2, 0), 1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_cleared_ready got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [8:0] held;
    drive(1'b1, mk(1, 3, 1, 0), 1'b1, 1'b0, 0, 1'b0);
    tick();
    held = {1'b1, 1'b0, 2'd1, 2'd3, 2'd1};
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, mk(3, 2, 3, 0), 1'b0, 1'b0, 0, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready cyc %0d got %b want 0", c, in_ready);
      end
      tick();
      n_checks++;
      if (d_out() !== held) begin
        n_fail++; $display("FAIL bp_hold cyc %0d got %h want %h", c, d_out(), held);
      end
    end
    drive(1'b1, mk(3, 2, 3, 0), 1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (d_out() !== {1'b1, 1'b0, 2'd3, 2'd2, 2'd3}) begin
      n_fail++; $display("FAIL bp_next got %h want %h", d_out(), {1'b1, 1'b0, 2'd3, 2'd2, 2'd3});
    end
  endtask

  task automatic test_collision();
    drive(1'b1, mk(0, 1, 0, 1), 1'b1, 1'b0, 0, 1'b0);
    tick();
    drive(1'b1, mk(0, 1, 0, 1), 1'b1, 1'b1, 1, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL coll_ready got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (d_out() !== {1'b1, 1'b1, 2'd0, 2'd1, 2'd0}) begin
      n_fail++; $display("FAIL coll_out got %h want %h", d_out(), {1'b1, 1'b1, 2'd0, 2'd1, 2'd0});
    end
    drive(1'b1, mk(1, 0, 0, 0), 1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (in_ready !== m_ready()) begin
      n_fail++; $display("FAIL coll_pending_ready got %b want %b", in_ready, m_ready());
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, mk(0, 2, 0, 1), 1'b1, 1'b0, 0, 1'b0);
    tick();
    drive(1'b1, mk(2, 0, 0, 0), 1'b0, 1'b0, 0, 1'b1);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready got %b want 0", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_rf_we} !== 2'b00) begin
      n_fail++; $display("FAIL flush_out got %b want 00", {out_valid, out_rf_we});
    end
    drive(1'b1, mk(2, 0, 2, 0), 1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_cleared_ready got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3, int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
      n_checks++;
      if (in_ready !== m_ready()) begin
        n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", c, in_ready, m_ready());
      end
      tick();
      n_checks++;
      if (d_out() !== m_out()) begin
        n_fail++; $display("FAIL rand_out cyc %0d got %h want %h", c, d_out(), m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_raw_stall();
    test_backpressure();
    test_collision();
    test_flush();
    test_random();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
